cp0_timer_unit: RTL

//  Parametrised CP0 Count/Compare timer for the MIPS core.
//  - Holds one free-running Count register and NCMP Compare channels.
//  - Count advances every CNT_DIV clocks. A per-channel pending interrupt is raised when Count reaches that channel's Compare.
//  - Sits beside the CP0 register file. mtc0/mfc0 and the hardware restore path share one write-data port and one read port.

---
 rtl/cp0_timer_unit_if.sv | 35 +++
 rtl/cp0_timer_unit.sv | 92 +++++++++
 2 files changed

// File: rtl/cp0_timer_unit_if.sv
// CP0 Count/Compare timer access bus: shared mtc0/restore write port, one read
// port and the per-channel interrupt lines.
interface cp0_timer_unit_if #(
    parameter int WIDTH = 32,
    parameter int NCMP  = 2
);
    localparam int SEL_W  = (NCMP > 1) ? $clog2(NCMP) : 1;
    localparam int RSEL_W = $clog2(NCMP + 1);

    // Protocol: there is no valid/ready pair. Each *_we strobe is a one-cycle
    // request that always completes at the next rising edge (the timer never
    // back-pressures). read_data is combinational and is valid in the same
    // cycle that re is high; it shows pre-edge register contents.
    logic              cnt_stall;
    logic              cnt_we_s;
    logic              cmp_we_s;
    logic              cmp_we_h;
    logic [SEL_W-1:0]  cmp_sel;
    logic [WIDTH-1:0]  write_data;
    logic              re;
    logic [RSEL_W-1:0] rd_sel;
    logic [WIDTH-1:0]  read_data;
    logic [NCMP-1:0]   timer_irq;
    logic              irq_any;

    modport master (
        output cnt_stall, cnt_we_s, cmp_we_s, cmp_we_h, cmp_sel, write_data, re, rd_sel,
        input  read_data, timer_irq, irq_any
    );

    modport slave (
        input  cnt_stall, cnt_we_s, cmp_we_s, cmp_we_h, cmp_sel, write_data, re, rd_sel,
        output read_data, timer_irq, irq_any
    );
endinterface

// File: rtl/cp0_timer_unit.sv
// CP0 Count/Compare timer: prescaled free-running Count and NCMP Compare
// channels, each raising a sticky interrupt on the rising edge of equality.
module cp0_timer_unit #(
    parameter int               WIDTH   = 32,
    parameter int               NCMP    = 2,
    parameter int               CNT_DIV = 2,
    parameter logic [WIDTH-1:0] RD_IDLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    cp0_timer_unit_if.slave  bus
);
    localparam int SEL_W  = (NCMP > 1) ? $clog2(NCMP) : 1;
    localparam int RSEL_W = $clog2(NCMP + 1);
    localparam int PRE_W  = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

    logic [PRE_W-1:0] prescaler;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] compare [NCMP];
    logic [NCMP-1:0]  pending;
    logic [NCMP-1:0]  match;
    logic [NCMP-1:0]  match_q;
    logic             tick;
    logic             cmp_we;

    assign tick   = (prescaler == PRE_W'(CNT_DIV - 1)) && !bus.cnt_stall;
    assign cmp_we = bus.cmp_we_s | bus.cmp_we_h;

    // A software Count write restarts the prescaler and overrides a debug stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            prescaler <= '0;
        end else if (bus.cnt_we_s) begin
            count     <= bus.write_data;
            prescaler <= '0;
        end else if (!bus.cnt_stall) begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
            if (tick) begin
                count <= count + WIDTH'(1);
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NCMP; i++) begin
            match[i] = (count == compare[i]);
        end
    end

    // match_q resets high so the equal reset values of Count and Compare do
    // not look like a fresh match. The software acknowledge beats a new set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCMP; i++) begin
                compare[i] <= '0;
            end
            pending <= '0;
            match_q <= '1;
        end else begin
            match_q <= match;
            for (int i = 0; i < NCMP; i++) begin
                if (cmp_we && (bus.cmp_sel == SEL_W'(i))) begin
                    compare[i] <= bus.write_data;
                end
                if (bus.cmp_we_s && (bus.cmp_sel == SEL_W'(i))) begin
                    pending[i] <= 1'b0;
                end else if (match[i] && !match_q[i]) begin
                    pending[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.read_data = RD_IDLE;
        if (bus.re) begin
            if (bus.rd_sel == '0) begin
                bus.read_data = count;
            end
            for (int i = 0; i < NCMP; i++) begin
                if (bus.rd_sel == RSEL_W'(i + 1)) begin
                    bus.read_data = compare[i];
                end
            end
        end
    end

    assign bus.timer_irq = pending;
    assign bus.irq_any   = |pending;
endmodule
